// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR latch command driver: FSM encoding,
// operation codes and the error-counter width with its saturating step.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    localparam int ERRCNT_W = 8;
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [ERRCNT_W-1:0] errcnt_sat_inc(input logic [ERRCNT_W-1:0] cnt);
        logic [ERRCNT_W-1:0] nxt;
        nxt = (cnt == ERRCNT_MAX) ? cnt : cnt + ERRCNT_W'(1);
        return nxt;
    endfunction

endpackage

// File: rtl/sr_fb_sync.sv
// Two-flop synchronizer for one asynchronous latch feedback bit.
// Both flops clear to 0 on the synchronous active-high reset.
module sr_fb_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Command-side driver for a cross-coupled NAND SR latch (active-low inputs).
// Accepts set/clear commands over valid/ready, emits a registered,
// never-overlapping active-low pulse on sbar or rbar, waits a gap, then
// checks the synchronized Q/Qbar feedback and reports done/err.
// Optional build macro SR_DRV_ERRCNT_EN enables the saturating error counter;
// without it err_cnt is a constant 0 and the port list is unchanged.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYC   = 2,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 4,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    output logic                sbar,
    output logic                rbar,
    input  logic                q_fb,
    input  logic                qbar_fb,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                latch_state,
    output logic [ERRCNT_W-1:0] err_cnt
);

    // Phase counters count down to zero, so each phase loads its length minus one.
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exp_op_q, exp_op_d;
    logic             finish_d;
    logic             finish_err_d;

    logic             q_sync;
    logic             qbar_sync;

    logic             sbar_q, sbar_d;
    logic             rbar_q, rbar_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             latch_state_q, latch_state_d;

    sr_fb_sync u_sync_q (
        .clk   (clk),
        .reset (reset),
        .d_i   (q_fb),
        .q_o   (q_sync)
    );

    sr_fb_sync u_sync_qbar (
        .clk   (clk),
        .reset (reset),
        .d_i   (qbar_fb),
        .q_o   (qbar_sync)
    );

    // FSM state, phase counter and the operation captured at accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            exp_op_q <= OP_CLR;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            exp_op_q <= exp_op_d;
        end
    end

    // Next-state logic: sequence PULSE -> GAP -> CHECK and judge the readback.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        exp_op_d     = exp_op_q;
        finish_d     = 1'b0;
        finish_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d  = PULSE;
                    exp_op_d = cmd_op;
                    cnt_d    = PULSE_LAST;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                    cnt_d   = TIMEOUT_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHECK: begin
                if (q_sync == qbar_sync) begin
                    // Both rails equal is never a legal latch state: fail at once.
                    state_d      = IDLE;
                    finish_d     = 1'b1;
                    finish_err_d = 1'b1;
                end else if (q_sync == exp_op_q) begin
                    state_d  = IDLE;
                    finish_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d      = IDLE;
                    finish_d     = 1'b1;
                    finish_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values derived from the next state so every output is a flop.
    // Only one of sbar/rbar can be selected by the single exp_op bit, so they never overlap.
    always_comb begin
        sbar_d        = ~((state_d == PULSE) && (exp_op_d == OP_SET));
        rbar_d        = ~((state_d == PULSE) && (exp_op_d == OP_CLR));
        cmd_ready_d   = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        done_d        = finish_d;
        err_d         = finish_err_d;
        latch_state_d = latch_state_q;
        if (finish_d && !finish_err_d) begin
            latch_state_d = exp_op_q;
        end
    end

    // Registered outputs; reset drives both latch inputs inactive.
    always_ff @(posedge clk) begin
        if (reset) begin
            sbar_q        <= 1'b1;
            rbar_q        <= 1'b1;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            latch_state_q <= 1'b0;
        end else begin
            sbar_q        <= sbar_d;
            rbar_q        <= rbar_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            latch_state_q <= latch_state_d;
        end
    end

`ifdef SR_DRV_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q;

    // Count failed completions, updating on the same edge that raises done/err.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (finish_d && finish_err_d) begin
            err_cnt_q <= errcnt_sat_inc(err_cnt_q);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign sbar        = sbar_q;
    assign rbar        = rbar_q;
    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign latch_state = latch_state_q;

endmodule
